// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, default parameter values and
// the PC wrap helper used by the fetch path.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'hE1A0_0000;
  localparam logic [31:0] PC_WRAP_DEF   = 32'd60;

  // Any address beyond the top legal byte address folds back to zero.
  function automatic logic [31:0] wrap_pc(input logic [31:0] pc, input logic [31:0] pc_wrap);
    logic [31:0] res;
    if (pc > pc_wrap) begin
      res = 32'd0;
    end else begin
      res = pc;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the fetch unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: branch over accept over hold, then wrap.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_WRAP = PC_WRAP_DEF
) (
  input  logic        branch_en,
  input  logic        accept,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_next
);

  logic [31:0] raw_s;

  // Priority select of the raw next PC, followed by the wrap check.
  always_comb begin
    raw_s = pc_out;
    if (branch_en) begin
      raw_s = branch_target;
    end else if (accept) begin
      raw_s = pc_out + 32'd4;
    end else begin
      raw_s = pc_out;
    end
    pc_next = wrap_pc(raw_s, PC_WRAP);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at r15, hands it to decode, and
// steers the value r15 loads next.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_WRAP   = PC_WRAP_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   PC_out,
  output logic [31:0]   PC_next,
  input  logic          branch_en,
  input  logic [31:0]   branch_target,
  fetch_unit_if.master  bus
);

  fetch_state_e state_r, state_s;
  logic [31:0]  instr_r, instr_s;
  logic         req_s, valid_s, accept_s;
  logic [31:0]  addr_s, pc_calc_s;

  // State and instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
      instr_r <= NOP_INSTR;
    end else begin
      state_r <= state_s;
      instr_r <= instr_s;
    end
  end

  // Next-state and handshake decode. While flushing, the instruction register
  // is not visible to decode, so it parks the abandoned request address.
  always_comb begin
    state_s  = state_r;
    instr_s  = instr_r;
    req_s    = 1'b0;
    valid_s  = 1'b0;
    accept_s = 1'b0;
    addr_s   = PC_out;
    case (state_r)
      FETCH: begin
        req_s = 1'b1;
        if (branch_en) begin
          if (bus.imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = FLUSH;
            instr_s = PC_out;
          end
        end else if (bus.imem_ack) begin
          state_s = HOLD;
          instr_s = bus.imem_rdata;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        valid_s = 1'b1;
        if (branch_en) begin
          state_s = FETCH;
        end else if (bus.instr_ready) begin
          accept_s = 1'b1;
          state_s  = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      FLUSH: begin
        req_s  = 1'b1;
        addr_s = instr_r;
        if (bus.imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = FETCH;
        instr_s = NOP_INSTR;
      end
    endcase
  end

  pc_next_calc #(.PC_WRAP(PC_WRAP)) u_pc_next_calc (
    .branch_en     (branch_en),
    .accept        (accept_s),
    .branch_target (branch_target),
    .pc_out        (PC_out),
    .pc_next       (pc_calc_s)
  );

  assign bus.imem_req    = req_s & ~rst;
  assign bus.imem_addr   = addr_s;
  assign bus.instr_valid = valid_s & ~rst;
  assign bus.instr       = bus.instr_valid ? instr_r : NOP_INSTR;
  assign PC_next         = rst ? 32'd0 : pc_calc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against an abstract model of the fetch/decode protocol.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'hE1A0_0000;
  localparam logic [31:0] WRAP = 32'd60;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic        branch_en;
  logic [31:0] branch_target;

  fetch_unit_if bus();

  fetch_unit #(.PC_WRAP(WRAP), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_out        (pc_out),
    .PC_next       (pc_next),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Abstract model: is a word waiting for decode, is a stale response owed.
  bit          m_hold, m_flush;
  logic [31:0] m_word, m_faddr;
  bit          c_br, c_ack, c_rdy;
  bit          e_req, e_valid;
  logic [31:0] e_addr, e_instr, e_pcn;
  bit          rand_data = 1'b0;

  task automatic apply(input bit br, input logic [31:0] tgt, input bit ack, input bit rdy);
    logic [31:0] raw;
    c_br = br; c_ack = ack; c_rdy = rdy;
    branch_en = br; branch_target = tgt;
    bus.imem_ack = ack; bus.instr_ready = rdy;
    e_req   = !m_hold;
    e_addr  = m_flush ? m_faddr : pc_out;
    e_valid = m_hold;
    e_instr = m_hold ? m_word : NOP;
    raw     = br ? tgt : ((m_hold && rdy) ? pc_out + 32'd4 : pc_out);
    e_pcn   = (raw > WRAP) ? 32'd0 : raw;
    #1;
    bus.imem_rdata = rand_data ? $urandom : (32'hA0 + bus.imem_addr);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (m_hold) begin
      if (c_br || c_rdy) m_hold = 1'b0;
    end else if (m_flush) begin
      if (c_ack) m_flush = 1'b0;
    end else if (c_br) begin
      if (!c_ack) begin
        m_flush = 1'b1;
        m_faddr = pc_out;
      end
    end else if (c_ack) begin
      m_hold = 1'b1;
      m_word = bus.imem_rdata;
    end
    pc_out = e_pcn;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_en = 1'b0; branch_target = 32'd0;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.imem_rdata = 32'd0;
    @(posedge clk);
    #1;
    pc_out = 32'd0; m_hold = 1'b0; m_flush = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    branch_en = 1'b0; branch_target = 32'd0; pc_out = 32'd0;
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.imem_rdata = 32'd0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_tests++; if (pc_next !== 32'd0) begin n_fail++; $display("FAIL reset_pcn: got %h want 0", pc_next); end
    n_tests++; if (bus.instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", bus.instr, NOP); end
    @(posedge clk);
    #1;
    pc_out = 32'd0; m_hold = 1'b0; m_flush = 1'b0;
    rst = 1'b0;
    apply(1'b0, 32'd0, 1'b0, 1'b0);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b want 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL release_addr: got %h want 0", bus.imem_addr); end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] got[$];
    logic [31:0] want_pcn [6] = '{32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 32'd0, 1'b1, 1'b1);
      n_tests++; if (bus.instr_valid !== ((i % 2) == 1)) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.instr_valid, (i % 2) == 1); end
      n_tests++; if (pc_next !== want_pcn[i]) begin n_fail++; $display("FAIL stream_pcn[%0d]: got %h want %h", i, pc_next, want_pcn[i]); end
      if (bus.instr_valid === 1'b1) got.push_back(bus.instr);
      advance();
    end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL stream_count: got %0d want 3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      n_tests++; if (got[k] !== 32'hA0 + 32'(4 * k)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, got[k], 32'hA0 + 32'(4 * k)); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1'b1, 32'd56, 1'b1, 1'b0);
    n_tests++; if (pc_next !== 32'd56) begin n_fail++; $display("FAIL wrap_branch_pcn: got %h want 38", pc_next); end
    advance();
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++; if (bus.imem_addr !== 32'd56) begin n_fail++; $display("FAIL wrap_addr56: got %h want 38", bus.imem_addr); end
    advance();
    apply(1'b0, 32'd0, 1'b0, 1'b1);
    n_tests++; if (pc_next !== 32'd60) begin n_fail++; $display("FAIL wrap_pcn60: got %h want 3c", pc_next); end
    n_tests++; if (bus.instr !== 32'hD8) begin n_fail++; $display("FAIL wrap_instr: got %h want d8", bus.instr); end
    advance();
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++; if (bus.imem_addr !== 32'd60) begin n_fail++; $display("FAIL wrap_addr60: got %h want 3c", bus.imem_addr); end
    advance();
    apply(1'b0, 32'd0, 1'b0, 1'b1);
    n_tests++; if (pc_next !== 32'd0) begin n_fail++; $display("FAIL wrap_pcn0: got %h want 0", pc_next); end
    advance();
  endtask

  task automatic test_stall();
    do_reset();
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 32'd0, 1'b1, 1'b0);
      n_tests++; if (bus.instr !== 32'hA0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h/%b want a0/1", i, bus.instr, bus.instr_valid); end
      n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.imem_req); end
      n_tests++; if (pc_next !== 32'd0) begin n_fail++; $display("FAIL stall_pcn[%0d]: got %h want 0", i, pc_next); end
      advance();
    end
    apply(1'b0, 32'd0, 1'b0, 1'b1);
    n_tests++; if (pc_next !== 32'd4) begin n_fail++; $display("FAIL stall_accept_pcn: got %h want 4", pc_next); end
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'd0, 1'b0, 1'b1);
      n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd4) begin n_fail++; $display("FAIL stall_single_accept[%0d]: got %b/%h want 0/4", i, bus.instr_valid, bus.imem_addr); end
      advance();
    end
  endtask

  task automatic test_flush();
    do_reset();
    apply(1'b1, 32'h20, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 32'h20) begin n_fail++; $display("FAIL flush_branch_pcn: got %h want 20", pc_next); end
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'd0, 1'b0, 1'b0);
      n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL flush_hold_req[%0d]: got %b/%h want 1/0", i, bus.imem_req, bus.imem_addr); end
      n_tests++; if (bus.instr_valid !== 1'b0 || pc_next !== 32'h20) begin n_fail++; $display("FAIL flush_state[%0d]: got %b/%h want 0/20", i, bus.instr_valid, pc_next); end
      advance();
    end
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++; if (bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL flush_ack_addr: got %h want 0", bus.imem_addr); end
    advance();
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++; if (bus.imem_addr !== 32'h20 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_refetch: got %h/%b want 20/0", bus.imem_addr, bus.instr_valid); end
    advance();
    apply(1'b0, 32'd0, 1'b0, 1'b0);
    n_tests++; if (bus.instr !== 32'hC0) begin n_fail++; $display("FAIL flush_new_instr: got %h want c0", bus.instr); end
    advance();
  endtask

  task automatic test_branch_accept();
    do_reset();
    apply(1'b0, 32'd0, 1'b1, 1'b0);
    advance();
    apply(1'b1, 32'h10, 1'b0, 1'b1);
    n_tests++; if (pc_next !== 32'h10) begin n_fail++; $display("FAIL bracc_pcn: got %h want 10", pc_next); end
    advance();
    apply(1'b0, 32'd0, 1'b0, 1'b0);
    n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL bracc_next: got %b/%h want 0/10", bus.instr_valid, bus.imem_addr); end
    advance();
  endtask

  task automatic test_rst_flush();
    do_reset();
    apply(1'b1, 32'h20, 1'b0, 1'b0);
    advance();
    apply(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0 || pc_next !== 32'd0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rstflush_during: got %b/%h/%b want 0/0/0", bus.instr_valid, pc_next, bus.imem_req); end
    bus.imem_ack = 1'b1;
    @(posedge clk);
    #1;
    pc_out = 32'd0; m_hold = 1'b0; m_flush = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'd0, 1'b0, 1'b1);
      n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL rstflush_after[%0d]: got %b/%b/%h want 0/1/0", i, bus.instr_valid, bus.imem_req, bus.imem_addr); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    do_reset();
    rand_data = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tgt = 32'($urandom_range(0, 17)) << 2;
      apply($urandom_range(0, 7) == 0, tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_tests++; if (bus.imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, bus.imem_req, e_req); end
      n_tests++; if (bus.instr_valid !== e_valid || bus.instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %b/%h want %b/%h", i, bus.instr_valid, bus.instr, e_valid, e_instr); end
      n_tests++; if (pc_next !== e_pcn) begin n_fail++; $display("FAIL rnd_pcn[%0d]: got %h want %h", i, pc_next, e_pcn); end
      if (e_req) begin
        n_tests++; if (bus.imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, bus.imem_addr, e_addr); end
      end
      n_tests++; if (bus.instr_valid === 1'b1 && bus.imem_req === 1'b1) begin n_fail++; $display("FAIL rnd_exclusive[%0d]: valid and req both 1", i); end
      advance();
    end
    rand_data = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_flush();
    test_branch_accept();
    test_rst_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WRAP, default 60, meaning the highest legal PC byte address; any larger PC wraps to 0.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE1A00000, meaning the instruction value driven on instr when instr_valid is low.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port PC_out, input, 32, the current PC read from register r15.
REQ-006 SHALL have port PC_next, output, 32, the value register r15 loads every clk edge.
REQ-007 SHALL have ports branch_en, input, 1 and branch_target, input, 32: a redirect request and its byte address.
REQ-008 SHALL have ports imem_req, output, 1; imem_addr, output, 32; imem_ack, input, 1; imem_rdata, input, 32: the instruction-memory handshake.
REQ-009 SHALL have ports instr, output, 32; instr_valid, output, 1; instr_ready, input, 1: the decode-side handshake.

Function
REQ-010 SHALL implement exactly three states: FETCH, HOLD and FLUSH.
REQ-011 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC_out; both SHALL be held stable until imem_ack.
REQ-012 In FETCH, when imem_ack=1 and branch_en=0, the block SHALL capture imem_rdata into an instruction register and go to HOLD on the next edge.
REQ-013 In HOLD, instr_valid SHALL be 1, instr SHALL equal the captured word, and imem_req SHALL be 0.
REQ-014 In HOLD, when instr_ready=1 (accept), the block SHALL return to FETCH on the next edge.
REQ-015 When instr_valid=0, instr SHALL equal NOP_INSTR.
REQ-016 PC_next SHALL be combinational, with priority branch > accept > hold.
REQ-017 On branch, PC_next SHALL equal branch_target; on accept, PC_next SHALL equal PC_out+4; otherwise PC_next SHALL equal PC_out.
REQ-018 The addition SHALL be unsigned 32-bit modulo 2^32, and any PC_next value greater than PC_WRAP SHALL be forced to 0.
REQ-019 branch_en in HOLD SHALL discard the held instruction (no accept, instr_valid low from the next cycle) and go to FETCH.
REQ-020 branch_en in FETCH with imem_ack=1 in the same cycle SHALL discard imem_rdata and stay in FETCH.
REQ-021 branch_en in FETCH with imem_ack=0 SHALL go to FLUSH.
REQ-022 In FLUSH, imem_req SHALL stay 1 and imem_addr SHALL stay at the old address until imem_ack; the returned data SHALL be discarded, then the block SHALL go to FETCH.
REQ-023 Any branch_en received while in FLUSH SHALL still update PC_next.
REQ-024 A fetch SHALL never complete in fewer than 2 cycles; with imem_ack tied high and instr_ready tied high, the block SHALL deliver one instruction every 2 cycles.
REQ-025 instr_valid SHALL never be 1 in the same cycle as imem_req.

Reset
REQ-026 While rst=1, the state SHALL be FETCH, the instruction register SHALL be NOP_INSTR, instr_valid SHALL be 0, PC_next SHALL be 0 and imem_req SHALL be 0.
REQ-027 On release of rst, imem_req SHALL assert on the first cycle with rst=0.
REQ-028 rst asserted mid-handshake SHALL abandon the outstanding request, and an imem_ack arriving after rst is released SHALL be ignored unless the block is in FETCH.

Structure
REQ-029 The state enum, NOP_INSTR and PC_WRAP defaults SHALL be defined in shared package cpu_pkg, which the register file also imports.
REQ-030 The PC_next computation (priority mux, +4 and wrap) SHALL be a single sub-module, pc_next_calc, that is purely combinational.
REQ-031 The state register and instruction register SHALL be the only flops.

Verification
REQ-032 Reset release, imem_ack=1 always, instr_ready=1 always, rdata=0xA0+addr -> instr sequence 0xA0, 0xA4, 0xA8, each valid one cycle in every two, with PC_next stepping 0, 4, 8.
REQ-033 PC_out=60, accept -> PC_next=0 (wrap); PC_out=56, accept -> PC_next=60.
REQ-034 In HOLD, instr_ready=0 for 5 cycles -> instr stable, PC_next=PC_out, no imem_req; then instr_ready=1 -> one accept only.
REQ-035 branch_en=1, target=0x20, in FETCH with imem_ack delayed 3 cycles -> FLUSH; old data discarded; next imem_addr=0x20; PC_next=0x20 in the branch cycle.
REQ-036 branch_en=1 and instr_ready=1 in the same HOLD cycle -> PC_next=branch_target, not PC_out+4, and instr_valid=0 next cycle.
REQ-037 rst pulsed during FLUSH -> instr_valid=0, PC_next=0, state FETCH, and a late imem_ack produces no instr_valid pulse.
